// File: rtl/config_chain_loader.sv
// -----------------------------------------------------------------------------
// config_chain_loader
//
// Loads the serial configuration chain of a CGRA tile array. Host words arrive
// on a valid/ready stream and are shifted LSB-first into the chain head, one
// bit per cycle. Shifting is gated so the chain holds still once it has taken
// CHAIN_LEN bits. The bits leaving the chain tail are packed back into words
// for readback.
//
// Ports:
//   config_clk      clock for this block and the chain
//   config_reset    synchronous, active-low reset
//   start           one-cycle pulse that begins a load (only honoured in IDLE)
//   abort           synchronous cancel of a load in progress
//   word_valid      host word available
//   word_data       host configuration word, bit 0 shifted first
//   word_ready      loader accepts word_data this cycle
//   chain_data      serial data into the first config_cell
//   chain_shift_en  chain clock-enable; chain shifts at the edge ending a
//                   cycle in which this is 1
//   chain_tail      serial data out of the last config_cell
//   rd_valid        one-cycle pulse, rd_data holds a readback word
//   rd_data         tail bits, first-out bit in bit 0, unfilled bits 0
//   busy            high while loading or shifting
//   done            one-cycle pulse when a full chain load completes
//   configured      level, set with done, cleared by start/abort/reset
// -----------------------------------------------------------------------------
module config_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = 16
) (
    input  logic              config_clk,
    input  logic              config_reset,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              chain_data,
    output logic              chain_shift_en,
    input  logic              chain_tail,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              configured
);

    localparam int              KW       = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [KW-1:0]   K_LAST   = KW'(WORD_W - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Place one tail bit into the readback word at the given bit position.
    function automatic logic [WORD_W-1:0] rb_insert(
        input logic [WORD_W-1:0] rb,
        input logic              tail_bit,
        input logic [KW-1:0]     pos
    );
        return rb | (WORD_W'(tail_bit) << pos);
    endfunction

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;          // remaining bits of the word being shifted
    logic [KW-1:0]     bit_idx_q, bit_idx_d;    // index of the bit on chain_data within its word
    logic [CNT_W-1:0]  bits_sent_q, bits_sent_d;
    logic [WORD_W-1:0] rb_q, rb_d;              // tail bits collected for the current word
    logic              word_ready_q, word_ready_d;
    logic              chain_data_q, chain_data_d;
    logic              chain_shift_en_q, chain_shift_en_d;
    logic              rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              configured_q, configured_d;

    logic [WORD_W-1:0] rb_next;
    logic              last_chain_bit;
    logic              word_end;

    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        bit_idx_d      = bit_idx_q;
        bits_sent_d    = bits_sent_q;
        rb_d           = rb_q;
        chain_data_d   = 1'b0;
        rd_valid_d     = 1'b0;
        rd_data_d      = rd_data_q;
        configured_d   = configured_q;

        rb_next        = rb_insert(rb_q, chain_tail, bit_idx_q);
        last_chain_bit = (bits_sent_q == BIT_LAST);
        // A word ends on its top bit, or early when the chain fills up; the
        // unused upper bits of a final partial word are simply dropped.
        word_end       = (bit_idx_q == K_LAST) || last_chain_bit;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    bits_sent_d  = '0;
                    configured_d = 1'b0;
                end
            end

            ST_LOAD: begin
                // abort wins over a word offered in the same cycle
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (word_valid && word_ready_q) begin
                    word_d       = word_data >> 1;
                    chain_data_d = word_data[0];
                    bit_idx_d    = '0;
                    rb_d         = '0;
                    state_d      = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    // A cancelled load never publishes a partial readback word.
                    state_d = ST_IDLE;
                    rb_d    = '0;
                end else begin
                    // chain_tail is sampled at the same edge that shifts the chain,
                    // so it is the bit that was sitting at the tail before the shift.
                    bits_sent_d = bits_sent_q + CNT_W'(1);
                    if (word_end) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = rb_next;
                        rb_d       = '0;
                        if (last_chain_bit) begin
                            state_d      = ST_DONE;
                            configured_d = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        rb_d         = rb_next;
                        bit_idx_d    = bit_idx_q + KW'(1);
                        chain_data_d = word_q[0];
                        word_d       = word_q >> 1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state so they line
        // up exactly with the state they describe.
        word_ready_d     = (state_d == ST_LOAD);
        chain_shift_en_d = (state_d == ST_SHIFT);
        busy_d           = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
        done_d           = (state_d == ST_DONE);
    end

    always_ff @(posedge config_clk) begin
        if (!config_reset) begin
            state_q          <= ST_IDLE;
            word_q           <= '0;
            bit_idx_q        <= '0;
            bits_sent_q      <= '0;
            rb_q             <= '0;
            word_ready_q     <= 1'b0;
            chain_data_q     <= 1'b0;
            chain_shift_en_q <= 1'b0;
            rd_valid_q       <= 1'b0;
            rd_data_q        <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            configured_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            word_q           <= word_d;
            bit_idx_q        <= bit_idx_d;
            bits_sent_q      <= bits_sent_d;
            rb_q             <= rb_d;
            word_ready_q     <= word_ready_d;
            chain_data_q     <= chain_data_d;
            chain_shift_en_q <= chain_shift_en_d;
            rd_valid_q       <= rd_valid_d;
            rd_data_q        <= rd_data_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            configured_q     <= configured_d;
        end
    end

    assign word_ready     = word_ready_q;
    assign chain_data     = chain_data_q;
    assign chain_shift_en = chain_shift_en_q;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign configured     = configured_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// -----------------------------------------------------------------------------
// tb_config_chain_loader
//
// Two loaders: a small one (20-bit chain, 8-bit words) and one at the default
// size (1024-bit chain, 32-bit words). Each drives a behavioural shift-register
// chain. Expected readback words are queued when a load is issued and checked
// by a separate monitor as rd_valid pulses appear.
// -----------------------------------------------------------------------------
module tb_config_chain_loader;

    localparam int AW = 8;
    localparam int AL = 20;
    localparam int BW = 32;
    localparam int BL = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- small instance ----------------
    logic          rst_a, start_a, abort_a, wv_a, wr_a, cd_a, se_a, tail_a;
    logic          rv_a, busy_a, done_a, cfg_a;
    logic [AW-1:0] wd_a, rdd_a;

    config_chain_loader #(.WORD_W(AW), .CHAIN_LEN(AL), .CNT_W(16)) dut_a (
        .config_clk(clk), .config_reset(rst_a), .start(start_a), .abort(abort_a),
        .word_valid(wv_a), .word_data(wd_a), .word_ready(wr_a),
        .chain_data(cd_a), .chain_shift_en(se_a), .chain_tail(tail_a),
        .rd_valid(rv_a), .rd_data(rdd_a), .busy(busy_a), .done(done_a),
        .configured(cfg_a)
    );

    logic [AL-1:0] chain_a, pre_val_a;
    logic          pre_a;
    always @(posedge clk) begin
        if (pre_a)     chain_a <= pre_val_a;
        else if (se_a) chain_a <= {cd_a, chain_a[AL-1:1]};
    end
    assign tail_a = chain_a[0];

    // ---------------- default-size instance ----------------
    logic          rst_b, start_b, abort_b, wv_b, wr_b, cd_b, se_b, tail_b;
    logic          rv_b, busy_b, done_b, cfg_b;
    logic [BW-1:0] wd_b, rdd_b;

    config_chain_loader dut_b (
        .config_clk(clk), .config_reset(rst_b), .start(start_b), .abort(abort_b),
        .word_valid(wv_b), .word_data(wd_b), .word_ready(wr_b),
        .chain_data(cd_b), .chain_shift_en(se_b), .chain_tail(tail_b),
        .rd_valid(rv_b), .rd_data(rdd_b), .busy(busy_b), .done(done_b),
        .configured(cfg_b)
    );

    logic [BL-1:0] chain_b, pre_val_b;
    logic          pre_b;
    always @(posedge clk) begin
        if (pre_b)     chain_b <= pre_val_b;
        else if (se_b) chain_b <= {cd_b, chain_b[BL-1:1]};
    end
    assign tail_b = chain_b[0];

    // ---------------- reference state and scoreboard ----------------
    logic [AL-1:0] ref_a;
    logic [BL-1:0] ref_b;
    logic [AW-1:0] exp_rd_a[$];
    logic [BW-1:0] exp_rd_b[$];
    int            runs_a[$];
    int            done_cnt_a = 0, done_cnt_b = 0, shift_total_b = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Chain content after m more bits of stream have been pushed in at the head.
    function automatic logic [AL-1:0] next_chain(input logic [AL-1:0] old,
                                                 input logic [AL-1:0] stream, input int m);
        logic [AL-1:0] one, mask;
        one = 1;
        if (m >= AL) return stream;
        mask = (one << m) - one;
        return (old >> m) | ((stream & mask) << (AL - m));
    endfunction

    // ---------------- monitors ----------------
    initial begin
        logic prev_rv, prev_se;
        int   run;
        prev_rv = 1'b0; prev_se = 1'b0; run = 0;
        forever begin
            @(negedge clk);
            if (rv_a) begin
                chk("a_rd_single_pulse", 64'(prev_rv), 64'd0);
                if (exp_rd_a.size() == 0) fail_now("a_rd_unexpected", $sformatf("rd_data 0x%0h with nothing queued", rdd_a));
                else chk("a_rd_data", 64'(rdd_a), 64'(exp_rd_a.pop_front()));
            end
            prev_rv = rv_a;
            if (!se_a) chk("a_chain_data_idle", 64'(cd_a), 64'd0);
            if (se_a) run++;
            else if (run > 0) begin runs_a.push_back(run); run = 0; end
            if (done_a) begin
                done_cnt_a++;
                chk("a_done_after_last_shift", 64'({prev_se, se_a}), 64'd2);
            end
            prev_se = se_a;
        end
    end

    initial begin
        logic prev_rv, prev_se;
        prev_rv = 1'b0; prev_se = 1'b0;
        forever begin
            @(negedge clk);
            if (rv_b) begin
                chk("b_rd_single_pulse", 64'(prev_rv), 64'd0);
                if (exp_rd_b.size() == 0) fail_now("b_rd_unexpected", $sformatf("rd_data 0x%0h with nothing queued", rdd_b));
                else chk("b_rd_data", 64'(rdd_b), 64'(exp_rd_b.pop_front()));
            end
            prev_rv = rv_b;
            if (!se_b) chk("b_chain_data_idle", 64'(cd_b), 64'd0);
            if (se_b) shift_total_b++;
            if (done_b) begin
                done_cnt_b++;
                chk("b_done_after_last_shift", 64'({prev_se, se_b}), 64'd2);
            end
            prev_se = se_b;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk_zero_a(input string tag);
        chk({tag, "_word_ready"}, 64'(wr_a), 64'd0);
        chk({tag, "_chain_data"}, 64'(cd_a), 64'd0);
        chk({tag, "_shift_en"},   64'(se_a), 64'd0);
        chk({tag, "_rd_valid"},   64'(rv_a), 64'd0);
        chk({tag, "_rd_data"},    64'(rdd_a), 64'd0);
        chk({tag, "_busy"},       64'(busy_a), 64'd0);
        chk({tag, "_done"},       64'(done_a), 64'd0);
        chk({tag, "_configured"}, 64'(cfg_a), 64'd0);
    endtask

    task automatic set_chain_a(input logic [AL-1:0] val);
        @(negedge clk);
        pre_a = 1'b1; pre_val_a = val;
        @(negedge clk);
        pre_a = 1'b0;
        ref_a = val;
    endtask

    // cut_kind: 0 = full load, 1 = abort, 2 = reset; the cut lands in shift
    // cycle cut_c (1-based) of word cut_w (0-based).
    task automatic run_load_a(input logic [AW-1:0] w0, input logic [AW-1:0] w1,
                              input logic [AW-1:0] w2, input int gap_len,
                              input int cut_kind, input int cut_w, input int cut_c,
                              input bit start_busy, input bit abort_with_start);
        logic [AW-1:0] w[3];
        logic [AL-1:0] stream, one, mask, tmp;
        int m, n_rd, nb, d0, k, last;
        bit ok;
        w[0] = w0; w[1] = w1; w[2] = w2;
        one = 1;
        stream = {w2[3:0], w1, w0};
        m    = (cut_kind == 0) ? AL : cut_w * AW + cut_c;
        n_rd = (cut_kind == 0) ? (AL + AW - 1) / AW : cut_w;
        for (int j = 0; j < n_rd; j++) begin
            nb   = (m - j * AW < AW) ? (m - j * AW) : AW;
            mask = (one << nb) - one;
            tmp  = (ref_a >> (j * AW)) & mask;
            exp_rd_a.push_back(tmp[AW-1:0]);
        end
        ref_a = next_chain(ref_a, stream, m);
        runs_a.delete();
        d0 = done_cnt_a;

        @(negedge clk);
        start_a = 1'b1; abort_a = abort_with_start;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        last = (cut_kind != 0) ? cut_w : 2;
        for (int i = 0; i <= last; i++) begin
            if (i == 1 && gap_len > 0) begin
                wv_a = 1'b0;
                ok = 1'b0;
                for (int t = 0; t < 100; t++) begin
                    if (wr_a) begin ok = 1'b1; break; end
                    @(negedge clk);
                end
                if (!ok) begin fail_now("a_gap_ready_timeout", "word_ready never returned"); return; end
                for (int g = 0; g < gap_len; g++) begin
                    chk("a_gap_no_shift", 64'(se_a), 64'd0);
                    start_a = start_busy && (g == 0);
                    @(negedge clk);
                end
                start_a = 1'b0;
            end
            wv_a = 1'b1; wd_a = w[i];
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                if (wr_a) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            if (!ok) begin fail_now("a_accept_timeout", $sformatf("word %0d never accepted", i)); wv_a = 1'b0; return; end
            @(posedge clk);
            @(negedge clk);
            chk("a_ready_drops_after_accept", 64'(wr_a), 64'd0);
            if (cut_kind != 0 && i == cut_w) begin
                k = 0;
                for (int t = 0; t < 50; t++) begin
                    if (se_a) k++;
                    if (k == cut_c) break;
                    @(negedge clk);
                end
                if (cut_kind == 1) abort_a = 1'b1;
                else               rst_a   = 1'b0;
                @(negedge clk);
                if (cut_kind == 1) begin
                    abort_a = 1'b0;
                    chk("a_abort_busy", 64'(busy_a), 64'd0);
                    chk("a_abort_shift_en", 64'(se_a), 64'd0);
                    chk("a_abort_word_ready", 64'(wr_a), 64'd0);
                    chk("a_abort_configured", 64'(cfg_a), 64'd0);
                    for (int t = 0; t < 5; t++) begin
                        @(negedge clk);
                        chk("a_abort_no_more_ready", 64'(wr_a), 64'd0);
                    end
                end else begin
                    chk_zero_a("a_reset_mid_shift");
                    rst_a = 1'b1;
                    @(negedge clk);
                end
            end
        end
        wv_a = 1'b0;

        if (cut_kind == 0) begin
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                if (done_a) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            if (!ok) fail_now("a_done_timeout", "done never pulsed");
            @(negedge clk);
            @(negedge clk);
            chk("a_done_once", 64'(done_cnt_a - d0), 64'd1);
            chk("a_configured", 64'(cfg_a), 64'd1);
            chk("a_busy_after_done", 64'(busy_a), 64'd0);
            chk("a_shift_runs", 64'(runs_a.size()), 64'd3);
            if (runs_a.size() == 3) begin
                chk("a_run0", 64'(runs_a[0]), 64'd8);
                chk("a_run1", 64'(runs_a[1]), 64'd8);
                chk("a_run2", 64'(runs_a[2]), 64'd4);
            end
        end else begin
            @(negedge clk);
            chk("a_cut_no_done", 64'(done_cnt_a - d0), 64'd0);
            chk("a_cut_configured", 64'(cfg_a), 64'd0);
        end
        chk("a_chain", 64'(chain_a), 64'(ref_a));
    endtask

    task automatic run_load_b();
        logic [BW-1:0] w[40];
        int  acc, d0, s0;
        bit  fin;
        for (int j = 0; j < 40; j++) w[j] = $urandom;
        for (int j = 0; j < BL / BW; j++) exp_rd_b.push_back(ref_b[j*BW +: BW]);
        for (int j = 0; j < BL / BW; j++) ref_b[j*BW +: BW] = w[j];
        d0 = done_cnt_b; s0 = shift_total_b; acc = 0; fin = 1'b0;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        for (int t = 0; t < 5000 && !fin; t++) begin
            wv_b = 1'b1; wd_b = w[acc % 40];
            if (done_b) fin = 1'b1;
            else if (wr_b) begin
                @(posedge clk);
                acc++;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end
        wv_b = 1'b0;
        if (!fin) fail_now("b_done_timeout", "done never pulsed");
        @(negedge clk);
        @(negedge clk);
        chk("b_words_accepted", 64'(acc), 64'd32);
        chk("b_done_once", 64'(done_cnt_b - d0), 64'd1);
        chk("b_shift_cycles", 64'(shift_total_b - s0), 64'(BL));
        chk("b_configured", 64'(cfg_b), 64'd1);
        checks++;
        if (chain_b !== ref_b) begin
            errors++;
            $display("FAIL b_chain: %0d bits differ, low word got 0x%0h expected 0x%0h",
                     $countones(chain_b ^ ref_b), chain_b[31:0], ref_b[31:0]);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int gl;
        rst_a = 1'b0; start_a = 1'b0; abort_a = 1'b0; wv_a = 1'b0; wd_a = '0;
        rst_b = 1'b0; start_b = 1'b0; abort_b = 1'b0; wv_b = 1'b0; wd_b = '0;
        pre_a = 1'b1; pre_val_a = '0; pre_b = 1'b1; pre_val_b = '0;
        ref_a = '0; ref_b = '0;
        repeat (3) @(negedge clk);
        pre_a = 1'b0; pre_b = 1'b0;
        chk_zero_a("a_reset");
        chk("b_reset_busy", 64'(busy_b), 64'd0);
        chk("b_reset_word_ready", 64'(wr_b), 64'd0);
        chk("b_reset_configured", 64'(cfg_b), 64'd0);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);

        // Basic load into an all-zero chain.
        run_load_a(8'hA5, 8'h3C, 8'h0F, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("a_s1_chain_literal", 64'(chain_a), 64'h0F3CA5);

        // Readback of a known chain image.
        set_chain_a(20'h12345);
        run_load_a(8'hA5, 8'h3C, 8'h0F, 0, 0, 0, 0, 1'b0, 1'b0);

        // Stalled host between words 1 and 2.
        set_chain_a(AL'($urandom));
        run_load_a(8'hA5, 8'h3C, 8'h0F, 5, 0, 0, 0, 1'b0, 1'b0);
        chk("a_s3_chain_literal", 64'(chain_a), 64'h0F3CA5);

        // Abort in the third shift cycle of word 2, then a clean reload.
        run_load_a(8'($urandom), 8'($urandom), 8'($urandom), 0, 1, 1, 3, 1'b0, 1'b0);
        run_load_a(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 0, 1'b0, 1'b0);

        // Reset in the fourth shift cycle of word 1, then a reload.
        run_load_a(8'($urandom), 8'($urandom), 8'($urandom), 0, 2, 0, 4, 1'b0, 1'b0);
        run_load_a(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 0, 1'b0, 1'b0);

        // Random loads with stalls, start pulses while busy, abort alongside start.
        for (int r = 0; r < 5; r++) begin
            gl = int'($urandom_range(0, 6));
            run_load_a(8'($urandom), 8'($urandom), 8'($urandom), gl, 0, 0, 0,
                       gl > 0, r[0]);
        end

        // Default-size loader: second load reads back the first load's words.
        run_load_b();
        run_load_b();

        repeat (3) @(negedge clk);
        chk("a_scoreboard_drained", 64'(exp_rd_a.size()), 64'd0);
        chk("b_scoreboard_drained", 64'(exp_rd_b.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
